// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, register bit positions,
// oversampling constants and the 2-of-3 majority helper.
package uart_pkg;

  localparam int OVS = 16;

  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_S2   = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  localparam int RXCON_EN   = 0;
  localparam int RXCON_PEN  = 1;
  localparam int RXCON_PODD = 2;
  localparam int RXCON_IEN  = 3;

  localparam int RXSTA_FULL = 0;
  localparam int RXSTA_FERR = 1;
  localparam int RXSTA_PERR = 2;
  localparam int RXSTA_OVR  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Register bus between the host strobe-write port and the UART receiver.
interface uart_rx_core_if;

  logic [15:0] icb_wdat;
  logic        uart_rxcon_wr;
  logic        uart_rxsta_wr;
  logic        uart_rxbuf_rd;
  logic [15:0] uart_rxcon;
  logic [15:0] uart_rxsta;
  logic [15:0] uart_rxbuf;
  logic        uart_rx_int;

  modport master (
    output icb_wdat, uart_rxcon_wr, uart_rxsta_wr, uart_rxbuf_rd,
    input  uart_rxcon, uart_rxsta, uart_rxbuf, uart_rx_int
  );

  modport slave (
    input  icb_wdat, uart_rxcon_wr, uart_rxsta_wr, uart_rxbuf_rd,
    output uart_rxcon, uart_rxsta, uart_rxbuf, uart_rx_int
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div+1 cycles, restartable by clr.
// Shared between the RX and TX paths.
module uart_baud_tick (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = (cnt == div);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled start/data/parity/stop deserialiser feeding a
// 1-deep receive buffer with sticky error flags and a level interrupt.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rx,
  input  logic [15:0] uart_baud,
  output logic        uart_rx_busy,
  uart_rx_core_if.slave bus
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rx_meta, rxs, rxs_d;
  rx_state_e         state;
  logic [3:0]        tick_idx;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        samp;
  logic              fr_pen, fr_podd, par_bad, stop_bit, done;
  logic [3:0]        rxcon_q;
  logic              rx_full, frame_err, par_err, overrun;
  logic [DATA_W-1:0] rxbuf_q;
  logic              baud_tick, start_det, maj, load;
  logic [15:0]       sta_clr;
  logic              unused_sta;

  assign start_det = (state == ST_IDLE) && rxcon_q[RXCON_EN] && rxs_d && !rxs;
  assign maj       = maj3(samp[1], samp[0], rxs);
  assign load      = done && (!rx_full || bus.uart_rxbuf_rd);
  assign sta_clr   = bus.uart_rxsta_wr ? bus.icb_wdat : 16'h0;
  assign unused_sta = ^{sta_clr[15:4], sta_clr[RXSTA_FULL]};

  uart_baud_tick u_baud (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (start_det),
    .div     (uart_baud),
    .tick    (baud_tick)
  );

  // Synchroniser presets high so a reset never looks like a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      tick_idx <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      samp     <= '0;
      fr_pen   <= 1'b0;
      fr_podd  <= 1'b0;
      par_bad  <= 1'b0;
      stop_bit <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && !rxcon_q[RXCON_EN]) begin
        state <= ST_IDLE;
      end else if (start_det) begin
        state    <= ST_START;
        tick_idx <= '0;
        fr_pen   <= rxcon_q[RXCON_PEN];
        fr_podd  <= rxcon_q[RXCON_PODD];
        par_bad  <= 1'b0;
      end else if (state != ST_IDLE && baud_tick) begin
        tick_idx <= tick_idx + 4'd1;
        if (tick_idx == TICK_S0) samp[1] <= rxs;
        if (tick_idx == TICK_S1) samp[0] <= rxs;
        case (state)
          ST_START: begin
            if (tick_idx == TICK_S2 && maj) begin
              state <= ST_IDLE;
            end else if (tick_idx == TICK_LAST) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (tick_idx == TICK_S2) begin
              shreg <= {maj, shreg[DATA_W-1:1]};
            end else if (tick_idx == TICK_LAST) begin
              if (bit_cnt == BIT_LAST) state <= fr_pen ? ST_PARITY : ST_STOP;
              else                     bit_cnt <= bit_cnt + BW'(1);
            end
          end
          ST_PARITY: begin
            if (tick_idx == TICK_S2)        par_bad <= (maj != ((^shreg) ^ fr_podd));
            else if (tick_idx == TICK_LAST) state <= ST_STOP;
          end
          ST_STOP: begin
            // Leave at the stop-bit centre so a back-to-back start edge is seen.
            if (tick_idx == TICK_S2) begin
              state    <= ST_IDLE;
              stop_bit <= maj;
              done     <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Error flags: a set in the same cycle as a write-1-to-clear takes priority.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxcon_q   <= '0;
      rx_full   <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
      rxbuf_q   <= '0;
    end else begin
      if (bus.uart_rxcon_wr) rxcon_q <= bus.icb_wdat[3:0];
      frame_err <= (frame_err & ~sta_clr[RXSTA_FERR]) | (done & ~stop_bit);
      par_err   <= (par_err   & ~sta_clr[RXSTA_PERR]) | (done & par_bad);
      overrun   <= (overrun   & ~sta_clr[RXSTA_OVR])  | (done & ~load);
      if (load) begin
        rxbuf_q <= shreg;
        rx_full <= 1'b1;
      end else if (bus.uart_rxbuf_rd) begin
        rx_full <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.uart_rxsta             = '0;
    bus.uart_rxsta[RXSTA_FULL] = rx_full;
    bus.uart_rxsta[RXSTA_FERR] = frame_err;
    bus.uart_rxsta[RXSTA_PERR] = par_err;
    bus.uart_rxsta[RXSTA_OVR]  = overrun;
  end

  assign bus.uart_rxcon  = {12'h000, rxcon_q};
  assign bus.uart_rxbuf  = 16'(rxbuf_q);
  assign bus.uart_rx_int = rxcon_q[RXCON_IEN] & (rx_full | frame_err | par_err | overrun);
  assign uart_rx_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames driven at uart_baud=3
// (64 clocks per bit), register state checked with immediate assertions.
module tb_uart_rx_core;

  localparam int BIT = 64;

  logic        sys_clk;
  logic        sys_rst;
  logic        uart_rx;
  logic [15:0] uart_baud;
  logic        uart_rx_busy;
  int          tests;
  int          fails;

  uart_rx_core_if bus ();

  uart_rx_core dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rx      (uart_rx),
    .uart_baud    (uart_baud),
    .uart_rx_busy (uart_rx_busy),
    .bus          (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic write_rxcon(input logic [15:0] v);
    @(negedge sys_clk);
    bus.icb_wdat      = v;
    bus.uart_rxcon_wr = 1'b1;
    @(negedge sys_clk);
    bus.uart_rxcon_wr = 1'b0;
  endtask

  task automatic write_rxsta(input logic [15:0] v);
    @(negedge sys_clk);
    bus.icb_wdat      = v;
    bus.uart_rxsta_wr = 1'b1;
    @(negedge sys_clk);
    bus.uart_rxsta_wr = 1'b0;
  endtask

  task automatic read_buf();
    @(negedge sys_clk);
    bus.uart_rxbuf_rd = 1'b1;
    @(negedge sys_clk);
    bus.uart_rxbuf_rd = 1'b0;
  endtask

  // Optionally pulses uart_rxbuf_rd in the cycle the received byte is loaded,
  // i.e. the first cycle after busy drops during the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_bit,
                            input logic stop_val, input bit rd_at_load);
    bit rd_done;
    rd_done = 1'b0;
    uart_rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_clks(BIT);
    end
    if (with_par) begin
      uart_rx = par_bit;
      wait_clks(BIT);
    end
    uart_rx = stop_val;
    for (int i = 0; i < BIT; i++) begin
      @(negedge sys_clk);
      bus.uart_rxbuf_rd = 1'b0;
      if (rd_at_load && !rd_done && !uart_rx_busy) begin
        bus.uart_rxbuf_rd = 1'b1;
        rd_done = 1'b1;
      end
    end
    @(negedge sys_clk);
    bus.uart_rxbuf_rd = 1'b0;
    if (rd_at_load) check("rd_load_sync", 16'(rd_done), 16'h0001);
    uart_rx = 1'b1;
    wait_clks(32);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sys_rst = 1'b1;
    uart_rx = 1'b1;
    uart_baud = 16'd3;
    bus.icb_wdat = '0;
    bus.uart_rxcon_wr = 1'b0;
    bus.uart_rxsta_wr = 1'b0;
    bus.uart_rxbuf_rd = 1'b0;
    wait_clks(4);
    sys_rst = 1'b0;
    wait_clks(2);

    check("rst_rxcon", bus.uart_rxcon, 16'h0000);
    check("rst_rxsta", bus.uart_rxsta, 16'h0000);
    check("rst_rxbuf", bus.uart_rxbuf, 16'h0000);
    check("rst_busy",  16'(uart_rx_busy), 16'h0000);
    check("rst_int",   16'(bus.uart_rx_int), 16'h0000);

    // 8N1 reception with interrupt enabled
    write_rxcon(16'h0009);
    check("rxcon_wr", bus.uart_rxcon, 16'h0009);
    send_frame(8'h3A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("8n1_rxbuf", bus.uart_rxbuf, 16'h003A);
    check("8n1_rxsta", bus.uart_rxsta, 16'h0001);
    check("8n1_int",   16'(bus.uart_rx_int), 16'h0001);
    check("8n1_busy",  16'(uart_rx_busy), 16'h0000);
    read_buf();
    check("rd_rxsta",  bus.uart_rxsta, 16'h0000);
    check("rd_int",    16'(bus.uart_rx_int), 16'h0000);
    check("rd_keeps_buf", bus.uart_rxbuf, 16'h003A);

    // Even parity: 0x3A has four ones, so the correct parity bit is 0
    write_rxcon(16'h000B);
    send_frame(8'h3A, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_even_ok", bus.uart_rxsta, 16'h0001);
    read_buf();
    send_frame(8'h3A, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_even_bad", bus.uart_rxsta, 16'h0005);
    check("par_bad_buf",  bus.uart_rxbuf, 16'h003A);
    write_rxsta(16'h0004);
    check("par_clr", bus.uart_rxsta, 16'h0001);
    read_buf();
    // Odd parity: correct bit for 0x3A is 1
    write_rxcon(16'h000F);
    send_frame(8'h3A, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_odd_ok", bus.uart_rxsta, 16'h0001);
    read_buf();

    // Framing error, then recovery with a good frame
    write_rxcon(16'h0009);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_rxbuf", bus.uart_rxbuf, 16'h00A5);
    check("ferr_rxsta", bus.uart_rxsta, 16'h0003);
    write_rxsta(16'h0003);
    check("ferr_clr_keeps_full", bus.uart_rxsta, 16'h0001);
    read_buf();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    check("recover_rxbuf", bus.uart_rxbuf, 16'h0011);
    check("recover_rxsta", bus.uart_rxsta, 16'h0001);
    read_buf();

    // Glitch shorter than half a bit is rejected as a false start
    uart_rx = 1'b0;
    wait_clks(16);
    check("glitch_busy_hi", 16'(uart_rx_busy), 16'h0001);
    uart_rx = 1'b1;
    wait_clks(BIT);
    check("glitch_busy_lo", 16'(uart_rx_busy), 16'h0000);
    check("glitch_rxsta",   bus.uart_rxsta, 16'h0000);
    check("glitch_rxbuf",   bus.uart_rxbuf, 16'h0011);

    // Receiver disabled: full frame ignored
    write_rxcon(16'h0000);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dis_rxbuf", bus.uart_rxbuf, 16'h0011);
    check("dis_rxsta", bus.uart_rxsta, 16'h0000);
    check("dis_busy",  16'(uart_rx_busy), 16'h0000);

    // Disable mid-frame aborts back to idle
    write_rxcon(16'h0009);
    uart_rx = 1'b0;
    wait_clks(BIT + 16);
    check("abort_busy_hi", 16'(uart_rx_busy), 16'h0001);
    write_rxcon(16'h0000);
    wait_clks(2);
    check("abort_busy_lo", 16'(uart_rx_busy), 16'h0000);
    uart_rx = 1'b1;
    wait_clks(12 * BIT);
    check("abort_rxsta", bus.uart_rxsta, 16'h0000);

    // Overrun, then read coinciding with load
    write_rxcon(16'h0009);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_first", bus.uart_rxsta, 16'h0001);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_rxbuf", bus.uart_rxbuf, 16'h0055);
    check("ovr_rxsta", bus.uart_rxsta, 16'h0009);
    check("ovr_int",   16'(bus.uart_rx_int), 16'h0001);
    write_rxsta(16'h0008);
    check("ovr_clr", bus.uart_rxsta, 16'h0001);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rdload_rxbuf", bus.uart_rxbuf, 16'h00AA);
    check("rdload_rxsta", bus.uart_rxsta, 16'h0001);
    read_buf();

    // Reset during data bit 4 of 0x3C
    uart_rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (8'h3C >> i) & 8'h01;
      wait_clks(BIT);
    end
    uart_rx = 1'b1;
    wait_clks(BIT / 2);
    check("midrst_busy_before", 16'(uart_rx_busy), 16'h0001);
    sys_rst = 1'b1;
    wait_clks(2);
    sys_rst = 1'b0;
    wait_clks(1);
    check("midrst_rxcon", bus.uart_rxcon, 16'h0000);
    check("midrst_rxsta", bus.uart_rxsta, 16'h0000);
    check("midrst_rxbuf", bus.uart_rxbuf, 16'h0000);
    check("midrst_busy",  16'(uart_rx_busy), 16'h0000);
    check("midrst_int",   16'(bus.uart_rx_int), 16'h0000);
    wait_clks(6 * BIT);
    write_rxcon(16'h0009);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    check("postrst_rxbuf", bus.uart_rxbuf, 16'h0081);
    check("postrst_rxsta", bus.uart_rxsta, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
